// File: rtl/spi_command_master.sv
// ============================================================================
// Module      : spi_command_master
// Description : SPI mode-0 master framing a command byte plus 0..2 argument bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_command_master #(
  parameter int CLK_DIV = 4,
  parameter int SS_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_code,
  input  logic [15:0] cmd_arg,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rx_byte,
  output logic        hw_spi_clk,
  output logic        hw_spi_ss,
  output logic        hw_spi_mosi,
  input  logic        hw_spi_miso
);

  localparam int c_cnt_w = (SS_GAP * CLK_DIV > 1) ? $clog2(SS_GAP * CLK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_div_reload = c_cnt_w'(CLK_DIV - 1);
  // The done/IDLE cycle is the last SS-high cycle of the gap, hence the -2.
  localparam logic [c_cnt_w-1:0] c_gap_reload = c_cnt_w'(SS_GAP * CLK_DIV - 2);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SETUP    = 3'd1,
    S_SHIFT_HI = 3'd2,
    S_SHIFT_LO = 3'd3,
    S_HOLD     = 3'd4,
    S_GAP      = 3'd5
  } state_t;

  state_t             r_state,    w_state;
  logic [c_cnt_w-1:0] r_cnt,      w_cnt;
  logic [23:0]        r_tx,       w_tx;
  logic [7:0]         r_rx_sh,    w_rx_sh;
  logic [7:0]         r_rx_byte,  w_rx_byte;
  logic [2:0]         r_bit_cnt,  w_bit_cnt;
  logic [1:0]         r_byte_idx, w_byte_idx;
  logic [1:0]         r_nbytes,   w_nbytes;
  logic               r_sclk,     w_sclk;
  logic               r_ss,       w_ss;
  logic               r_mosi,     w_mosi;
  logic               r_done,     w_done;
  logic [1:0]         w_frame_n;

  function automatic logic [1:0] frame_bytes(input logic [7:0] code);
    case (code)
      8'h00, 8'hFF:                      frame_bytes = 2'd1;
      8'h01, 8'h02, 8'h03, 8'h06, 8'h0B: frame_bytes = 2'd2;
      default:                           frame_bytes = 2'd3;
    endcase
  endfunction

  assign w_frame_n = frame_bytes(cmd_code);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_tx       <= '0;
      r_rx_sh    <= '0;
      r_rx_byte  <= '0;
      r_bit_cnt  <= '0;
      r_byte_idx <= '0;
      r_nbytes   <= '0;
      r_sclk     <= 1'b0;
      r_ss       <= 1'b1;
      r_mosi     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_tx       <= w_tx;
      r_rx_sh    <= w_rx_sh;
      r_rx_byte  <= w_rx_byte;
      r_bit_cnt  <= w_bit_cnt;
      r_byte_idx <= w_byte_idx;
      r_nbytes   <= w_nbytes;
      r_sclk     <= w_sclk;
      r_ss       <= w_ss;
      r_mosi     <= w_mosi;
      r_done     <= w_done;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_tx       = r_tx;
    w_rx_sh    = r_rx_sh;
    w_rx_byte  = r_rx_byte;
    w_bit_cnt  = r_bit_cnt;
    w_byte_idx = r_byte_idx;
    w_nbytes   = r_nbytes;
    w_sclk     = r_sclk;
    w_ss       = r_ss;
    w_mosi     = r_mosi;
    w_done     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_nbytes   = w_frame_n;
          case (w_frame_n)
            2'd1:    w_tx = {cmd_code, 16'h0000};
            2'd2:    w_tx = {cmd_code, cmd_arg[7:0], 8'h00};
            default: w_tx = {cmd_code, cmd_arg};
          endcase
          w_ss       = 1'b0;
          w_mosi     = cmd_code[7];
          w_cnt      = c_div_reload;
          w_bit_cnt  = '0;
          w_byte_idx = '0;
          w_state    = S_SETUP;
        end
      end
      S_SETUP, S_SHIFT_LO: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - c_cnt_w'(1);
        end else if (r_state == S_SHIFT_LO && r_byte_idx == r_nbytes) begin
          w_cnt   = c_div_reload;
          w_state = S_HOLD;
        end else begin
          // Rising SCLK edge: capture MISO as SCLK goes high.
          w_sclk  = 1'b1;
          w_rx_sh = {r_rx_sh[6:0], hw_spi_miso};
          w_cnt   = c_div_reload;
          w_state = S_SHIFT_HI;
        end
      end
      S_SHIFT_HI: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - c_cnt_w'(1);
        end else begin
          w_sclk    = 1'b0;
          w_tx      = {r_tx[22:0], 1'b0};
          w_mosi    = r_tx[22];
          w_bit_cnt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_rx_byte  = r_rx_sh;
            w_byte_idx = r_byte_idx + 2'd1;
          end
          w_cnt   = c_div_reload;
          w_state = S_SHIFT_LO;
        end
      end
      S_HOLD: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - c_cnt_w'(1);
        end else begin
          w_ss    = 1'b1;
          w_mosi  = 1'b0;
          w_cnt   = c_gap_reload;
          w_state = S_GAP;
        end
      end
      S_GAP: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - c_cnt_w'(1);
        end else begin
          w_done  = 1'b1;
          w_state = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign cmd_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE) | r_done;
  assign done        = r_done;
  assign rx_byte     = r_rx_byte;
  assign hw_spi_clk  = r_sclk;
  assign hw_spi_ss   = r_ss;
  assign hw_spi_mosi = r_mosi;

endmodule

`default_nettype wire

// File: tb/tb_spi_command_master.sv
// ============================================================================
// Module      : tb_spi_command_master
// Description : Directed self-checking bench for spi_command_master.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_command_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_code = 8'h00;
  logic [15:0] cmd_arg = 16'h0000;
  logic        busy;
  logic        done;
  logic [7:0]  rx_byte;
  logic        hw_spi_clk;
  logic        hw_spi_ss;
  logic        hw_spi_mosi;
  logic        hw_spi_miso;

  logic        loop_en = 1'b0;
  logic [7:0]  miso_byte = 8'h00;
  logic [2:0]  miso_idx;

  int checks = 0;
  int failures = 0;

  int cyc = 0, low_cnt = 0, high_cnt = 0, last_low = 0, last_high = 0;
  int rises = 0, last_rises = 0, acc_cyc = 0, done_cyc = 0, nbits = 0;
  int d1 = 0;
  logic       prev_ss = 1'b1;
  logic       prev_sclk = 1'b0;
  logic [7:0] sh = 8'h00;
  logic [7:0] bytes_q[$];

  spi_command_master #(.CLK_DIV(4), .SS_GAP(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_code    (cmd_code),
    .cmd_arg     (cmd_arg),
    .busy        (busy),
    .done        (done),
    .rx_byte     (rx_byte),
    .hw_spi_clk  (hw_spi_clk),
    .hw_spi_ss   (hw_spi_ss),
    .hw_spi_mosi (hw_spi_mosi),
    .hw_spi_miso (hw_spi_miso)
  );

  always #5 clk = ~clk;

  // Slave reply: every byte of a frame returns miso_byte, MSB first.
  assign miso_idx    = 3'(7 - (rises % 8));
  assign hw_spi_miso = loop_en ? hw_spi_mosi : miso_byte[miso_idx];

  // Link monitor and slave byte decoder, sampled 1 ns after each clk edge.
  always @(posedge clk) begin
    #1;
    cyc <= cyc + 1;
    if (!hw_spi_ss) begin
      if (prev_ss) begin
        last_high <= high_cnt;
        low_cnt   <= 1;
        rises     <= 0;
        nbits     <= 0;
        acc_cyc   <= cyc;
      end else begin
        low_cnt <= low_cnt + 1;
        if (hw_spi_clk && !prev_sclk) begin
          rises <= rises + 1;
          sh    <= {sh[6:0], hw_spi_mosi};
          if (nbits == 7) begin
            bytes_q.push_back({sh[6:0], hw_spi_mosi});
            nbits <= 0;
          end else begin
            nbits <= nbits + 1;
          end
        end
      end
    end else begin
      if (!prev_ss) begin
        last_low   <= low_cnt;
        last_rises <= rises;
        high_cnt   <= 1;
      end else begin
        high_cnt <= high_cnt + 1;
      end
    end
    if (done) done_cyc <= cyc;
    prev_ss   <= hw_spi_ss;
    prev_sclk <= hw_spi_clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] code, input logic [15:0] arg);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_code  = code;
    cmd_arg   = arg;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_code  = 8'h5A;
    cmd_arg   = 16'hFFFF;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_seen", {31'b0, done}, 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ss",    {31'b0, hw_spi_ss},   32'd1);
    check("rst_sclk",  {31'b0, hw_spi_clk},  32'd0);
    check("rst_mosi",  {31'b0, hw_spi_mosi}, 32'd0);
    check("rst_ready", {31'b0, cmd_ready},   32'd1);
    check("rst_busy",  {31'b0, busy},        32'd0);
    check("rst_done",  {31'b0, done},        32'd0);
    check("rst_rx",    {24'b0, rx_byte},     32'h00);

    // 0-arg frame
    bytes_q.delete();
    miso_byte = 8'hC3;
    send(8'h00, 16'h1234);
    wait_done();
    check("f0_len",   32'(done_cyc - acc_cyc + 1), 32'd80);
    check("f0_sslow", 32'(last_low),   32'd72);
    check("f0_rises", 32'(last_rises), 32'd8);
    check("f0_nbyte", 32'(bytes_q.size()), 32'd1);
    if (bytes_q.size() >= 1) check("f0_b0", {24'b0, bytes_q[0]}, 32'h00);
    check("f0_rx",    {24'b0, rx_byte}, 32'hC3);
    check("f0_busy_at_done", {31'b0, busy}, 32'd1);
    check("f0_ready_at_done", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    check("f0_done_pulse", {31'b0, done}, 32'd0);
    check("f0_busy_after", {31'b0, busy}, 32'd0);

    // 1-arg frame
    bytes_q.delete();
    miso_byte = 8'h3C;
    send(8'h03, 16'h0002);
    wait_done();
    check("f1_len",   32'(done_cyc - acc_cyc + 1), 32'd144);
    check("f1_sslow", 32'(last_low),   32'd136);
    check("f1_rises", 32'(last_rises), 32'd16);
    check("f1_nbyte", 32'(bytes_q.size()), 32'd2);
    if (bytes_q.size() >= 2) begin
      check("f1_b0", {24'b0, bytes_q[0]}, 32'h03);
      check("f1_b1", {24'b0, bytes_q[1]}, 32'h02);
    end
    check("f1_rx", {24'b0, rx_byte}, 32'h3C);

    // 2-arg frame
    bytes_q.delete();
    send(8'h04, 16'h0F38);
    wait_done();
    check("f2_len",   32'(done_cyc - acc_cyc + 1), 32'd208);
    check("f2_sslow", 32'(last_low),   32'd200);
    check("f2_rises", 32'(last_rises), 32'd24);
    check("f2_nbyte", 32'(bytes_q.size()), 32'd3);
    if (bytes_q.size() >= 3) begin
      check("f2_b0", {24'b0, bytes_q[0]}, 32'h04);
      check("f2_b1", {24'b0, bytes_q[1]}, 32'h0F);
      check("f2_b2", {24'b0, bytes_q[2]}, 32'h38);
    end

    // 0xFF is an ordinary 0-arg frame
    bytes_q.delete();
    send(8'hFF, 16'hABCD);
    wait_done();
    check("ff_rises", 32'(last_rises), 32'd8);
    check("ff_nbyte", 32'(bytes_q.size()), 32'd1);
    if (bytes_q.size() >= 1) check("ff_b0", {24'b0, bytes_q[0]}, 32'hFF);

    // Back-to-back with cmd_valid held; inputs change after the first acceptance
    bytes_q.delete();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_code  = 8'h01;
    cmd_arg   = 16'h0001;
    @(negedge clk);
    cmd_code  = 8'h0A;
    cmd_arg   = 16'h0123;
    wait_done();
    d1 = done_cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b_accept_on_done", 32'(acc_cyc - d1), 32'd1);
    wait_done();
    check("b2b_ss_gap", 32'(last_high), 32'd8);
    check("b2b_nbyte", 32'(bytes_q.size()), 32'd5);
    if (bytes_q.size() >= 5) begin
      check("b2b_b0", {24'b0, bytes_q[0]}, 32'h01);
      check("b2b_b1", {24'b0, bytes_q[1]}, 32'h01);
      check("b2b_b2", {24'b0, bytes_q[2]}, 32'h0A);
      check("b2b_b3", {24'b0, bytes_q[3]}, 32'h01);
      check("b2b_b4", {24'b0, bytes_q[4]}, 32'h23);
    end

    // Loopback
    loop_en = 1'b1;
    bytes_q.delete();
    send(8'h0B, 16'h00A5);
    for (int i = 0; i < 400 && rises < 9; i++) @(negedge clk);
    check("lb_first_byte", {24'b0, rx_byte}, 32'h0B);
    wait_done();
    check("lb_final_byte", {24'b0, rx_byte}, 32'hA5);
    loop_en = 1'b0;

    // Reset in the middle of the second byte of a 3-byte frame
    miso_byte = 8'h99;
    send(8'h04, 16'h0F38);
    for (int i = 0; i < 400 && rises < 12; i++) @(negedge clk);
    check("mid_pre_ss", {31'b0, hw_spi_ss}, 32'd0);
    check("mid_pre_rx", {24'b0, rx_byte}, 32'h99);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_ss",   {31'b0, hw_spi_ss},   32'd1);
    check("mid_sclk", {31'b0, hw_spi_clk},  32'd0);
    check("mid_mosi", {31'b0, hw_spi_mosi}, 32'd0);
    check("mid_busy", {31'b0, busy},        32'd0);
    check("mid_rx",   {24'b0, rx_byte},     32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_ready", {31'b0, cmd_ready}, 32'd1);
    bytes_q.delete();
    miso_byte = 8'hC3;
    send(8'h00, 16'h0000);
    wait_done();
    check("post_rises", 32'(last_rises), 32'd8);
    check("post_nbyte", 32'(bytes_q.size()), 32'd1);
    if (bytes_q.size() >= 1) check("post_b0", {24'b0, bytes_q[0]}, 32'h00);
    check("post_rx", {24'b0, rx_byte}, 32'hC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_command_master.md
Name: spi_command_master

Overview:
- SPI mode-0 master that serialises control commands (command byte plus 0, 1 or 2 argument bytes) onto the hardware SPI link consumed by the pipeline's SPI control slave.
- Used as the host-side driver in loopback benches and on boards where on-FPGA logic (test-pattern sequencer, boot configurator) programs the pipeline control registers.
- Accepts one command at a time through a valid/ready handshake, frames each command with its own slave-select assertion, and signals completion.

Parameters:
- CLK_DIV, 4, system clocks per SPI half-period; legal range >= 2.
- SS_GAP, 2, SPI half-periods that slave-select stays high between frames; legal range >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  master can accept a command
- cmd_code  in  8  command byte
- cmd_arg  in  16  argument; 1-arg commands use [7:0], 2-arg commands use the full value
- busy  out  1  frame in progress, including the SS gap
- done  out  1  one-cycle pulse when a frame (including its gap) completes
- rx_byte  out  8  last byte shifted in on hw_spi_miso
- hw_spi_clk  out  1  SPI clock, idles low
- hw_spi_ss  out  1  slave select, active low
- hw_spi_mosi  out  1  serial data out, MSB first
- hw_spi_miso  in  1  serial data in, sampled on the rising SCLK edge

Behaviour:
- Reset (asynchronous, immediate, also mid-frame) sets these values:
  - hw_spi_ss=1, hw_spi_clk=0, hw_spi_mosi=0
  - cmd_ready=1 once reset releases, busy=0, done=0, rx_byte=0
  - FSM=IDLE, all counters cleared
- Handshake:
  - cmd_ready=1 only in IDLE.
  - The command is accepted on a clk edge where cmd_valid & cmd_ready are both high; cmd_code and cmd_arg are latched internally on that edge.
  - Input changes after acceptance have no effect on the frame.
- Byte count, decided from cmd_code at acceptance:
  - 0 args: 0x00, 0xFF.
  - 1 arg: 0x01, 0x02, 0x03, 0x06, 0x0B.
  - 2 args: every other code, including 0x04, 0x05, 0x07–0x0A, 0x0C and undefined codes.
  - Frame length N = 1, 2 or 3 bytes.
- Byte order:
  - The command byte goes first.
  - 1-arg frames then send cmd_arg[7:0].
  - 2-arg frames send cmd_arg[15:8], then cmd_arg[7:0].
- FSM states: IDLE -> SETUP -> SHIFT_LO <-> SHIFT_HI -> HOLD -> GAP -> IDLE.
  - IDLE: hw_spi_ss=1. On acceptance, drive hw_spi_ss=0 and hw_spi_mosi to bit 7 of the command byte, then enter SETUP.
  - SETUP: wait CLK_DIV cycles with SCLK low, then enter SHIFT_HI.
  - SHIFT_HI: hw_spi_clk=1 for CLK_DIV cycles. Sample hw_spi_miso into the receive shifter on entry (the rising edge).
  - SHIFT_LO: hw_spi_clk=0 for CLK_DIV cycles. hw_spi_mosi updates to the next bit on entry (the falling edge).
  - After bit 0 of a non-final byte, the next byte's bit 7 is presented on that falling edge; there is no extra idle between bytes and SS stays low.
  - After the falling edge following bit 0 of the final byte, enter HOLD. rx_byte updates at each byte boundary.
  - HOLD: SCLK low, SS low, for CLK_DIV cycles. Then hw_spi_ss=1, hw_spi_mosi=0, enter GAP.
  - GAP: SS high for SS_GAP*CLK_DIV cycles. On exit, pulse done for one cycle and enter IDLE, with cmd_ready=1 in the same cycle.
- Timing:
  - Frame duration from the acceptance edge to the done pulse is CLK_DIV*(2 + 16*N + SS_GAP) cycles, exact.
  - Exactly 8*N SCLK rising edges per SS-low window.
  - busy=1 from the cycle after acceptance until done, inclusive.
- Back-to-back commands: a cmd_valid held high is accepted on the done cycle. SS always deasserts for the full gap between frames, so the slave returns to its awaiting-command state.
- Command code 0xFF is transmitted like any other 0-arg frame; the master does not filter codes.
- The counter for half-periods is ceil(log2(max(CLK_DIV, SS_GAP*CLK_DIV))) bits wide and wraps only on explicit reload, never freely.

Test Plan:
- 0-arg frame: reset, send cmd_code=0x00 with CLK_DIV=4 and SS_GAP=2 -> SS low for exactly 4*(2+16)=72 cycles; 8 rising SCLK edges; MOSI pattern 00000000; done pulses at cycle 80 after acceptance.
- 1-arg frame: send 0x03 with cmd_arg=0x0002 -> 16 edges; bytes decoded by an SPI slave model are 0x03, 0x02; the pipeline control slave sets ctrl_fg_scale=2.
- 2-arg frame: send 0x04 with cmd_arg=0x0F38 -> bytes 0x04, 0x0F, 0x38; ctrl_fg_offset_x=0x738 (PRECISION=11); frame length 4*(2+48+2)=208 cycles.
- Back-to-back: send 0x01/0x0001 immediately followed by 0x0A/0x0123 with cmd_valid held high -> second acceptance occurs on the done cycle; SS stays high for exactly 8 cycles between frames; ctrl_overlay_mode=1 and ctrl_fg_clip_bottom=0x123.
- Loopback: tie hw_spi_miso to hw_spi_mosi and send 0x0B/0x00A5 -> rx_byte reads 0x0B after the first byte and 0xA5 at done.
- Reset mid-frame: assert rst_n low during the 2nd byte of a 3-byte frame -> SS=1, SCLK=0, MOSI=0 asynchronously in the same cycle; after release cmd_ready=1, and the next 0x00 frame is decoded correctly by the slave.
